// File: rtl/instruction_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache_pkg
// Description : Shared defaults, FSM state encoding and halfword helper for
//               the direct-mapped instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_cache_pkg;

   // Default geometry: 32 lines of 4 words (16-byte lines)
   localparam int ICACHE_INDEX_BIT  = 5;
   localparam int ICACHE_LINE_WORDS = 4;

   // Refill controller states
   typedef enum logic [0:0] {
      IC_IDLE = 1'b0,
      IC_FILL = 1'b1
   } ic_state_t;

   // Select the halfword addressed by pc[1] out of a 32-bit word
   function automatic logic [15:0] pick_half(input logic [31:0] word, input logic sel);
      return sel ? word[31:16] : word[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache
// Description : Direct-mapped instruction cache. Combinational fetch lookup
//               over two halfword ports (pc and pc+2) so compressed and
//               line-straddling 32-bit instructions are served; line refill
//               from the memory unit on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache
   import instruction_cache_pkg::*;
#(
   parameter int INDEX_BIT  = ICACHE_INDEX_BIT,
   parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   output logic        inst_ready,
   output logic [31:0] inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_data
);

   localparam int c_WSEL_BIT   = $clog2(LINE_WORDS);
   localparam int c_OFFSET_BIT = c_WSEL_BIT + 2;
   localparam int c_TAG_BIT    = 32 - c_OFFSET_BIT - INDEX_BIT;
   localparam int c_LINES      = 1 << INDEX_BIT;
   localparam logic [c_WSEL_BIT-1:0] c_LAST_BEAT = c_WSEL_BIT'(LINE_WORDS - 1);

   // Storage arrays
   logic [c_LINES-1:0]   r_valid;
   logic [c_TAG_BIT-1:0] r_tag  [c_LINES];
   logic [31:0]          r_data [c_LINES][LINE_WORDS];

   // Refill control
   ic_state_t               r_state;
   ic_state_t               w_state_next;
   logic                    r_mem_req;
   logic [31:0]             r_mem_addr;
   logic [c_WSEL_BIT-1:0]   r_cnt;
   logic [INDEX_BIT-1:0]    r_fill_idx;
   logic                    w_start;
   logic                    w_beat;
   logic                    w_last;

   // Lookup ports
   logic [31:0]             w_lo_pc;
   logic [31:0]             w_hi_pc;
   logic [INDEX_BIT-1:0]    w_lo_idx;
   logic [INDEX_BIT-1:0]    w_hi_idx;
   logic [c_TAG_BIT-1:0]    w_lo_tag;
   logic [c_TAG_BIT-1:0]    w_hi_tag;
   logic [c_WSEL_BIT-1:0]   w_lo_wsel;
   logic [c_WSEL_BIT-1:0]   w_hi_wsel;
   logic                    w_lo_hit;
   logic                    w_hi_hit;
   logic [15:0]             w_lo_half;
   logic [15:0]             w_hi_half;
   logic                    w_is16;

   // Miss target
   logic [31:0]             w_miss_pc;
   logic [31:0]             w_miss_base;
   logic [INDEX_BIT-1:0]    w_miss_idx;
   logic [c_TAG_BIT-1:0]    w_miss_tag;

   // Halfword alignment makes bit 0 of both lookup addresses meaningless
   logic                    w_unused;
   assign w_unused = ^{fetch_pc[0], w_hi_pc[0]};

   // hi = pc+2; the full 32-bit add carries into index and tag, so a
   // straddle out of the last line wraps to line 0 with tag+1 naturally
   assign w_lo_pc   = fetch_pc;
   assign w_hi_pc   = fetch_pc + 32'd2;

   assign w_lo_idx  = w_lo_pc[c_OFFSET_BIT +: INDEX_BIT];
   assign w_hi_idx  = w_hi_pc[c_OFFSET_BIT +: INDEX_BIT];
   assign w_lo_tag  = w_lo_pc[31 -: c_TAG_BIT];
   assign w_hi_tag  = w_hi_pc[31 -: c_TAG_BIT];
   assign w_lo_wsel = w_lo_pc[2 +: c_WSEL_BIT];
   assign w_hi_wsel = w_hi_pc[2 +: c_WSEL_BIT];

   assign w_lo_hit  = r_valid[w_lo_idx] && (r_tag[w_lo_idx] == w_lo_tag);
   assign w_hi_hit  = r_valid[w_hi_idx] && (r_tag[w_hi_idx] == w_hi_tag);

   assign w_lo_half = pick_half(r_data[w_lo_idx][w_lo_wsel], w_lo_pc[1]);
   assign w_hi_half = pick_half(r_data[w_hi_idx][w_hi_wsel], w_hi_pc[1]);

   // Low two bits of 2'b11 mark a full 32-bit instruction
   assign w_is16     = (w_lo_half[1:0] != 2'b11);
   assign inst_ready = fetch_req && w_lo_hit && (w_is16 || w_hi_hit);
   assign inst       = {w_hi_half, w_lo_half};

   // The lo line is always fetched first; hi is only refilled once lo hits
   assign w_miss_pc   = w_lo_hit ? w_hi_pc : w_lo_pc;
   assign w_miss_base = {w_miss_pc[31:c_OFFSET_BIT], {c_OFFSET_BIT{1'b0}}};
   assign w_miss_idx  = w_miss_pc[c_OFFSET_BIT +: INDEX_BIT];
   assign w_miss_tag  = w_miss_pc[31 -: c_TAG_BIT];

   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;

   // Next-state and strobe decode; beats outside FILL are ignored
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_beat       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IC_IDLE: begin
            if (fetch_req && !inst_ready) begin
               w_start      = 1'b1;
               w_state_next = IC_FILL;
            end
         end
         IC_FILL: begin
            if (mem_valid) begin
               w_beat = 1'b1;
               if (r_cnt == c_LAST_BEAT) begin
                  w_last       = 1'b1;
                  w_state_next = IC_IDLE;
               end
            end
         end
         default: w_state_next = IC_IDLE;
      endcase
   end

   // State register; frozen while paused
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= IC_IDLE;
      end else if (rdy_in) begin
         r_state <= w_state_next;
      end
   end

   // Refill request, beat counter and valid bits
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_mem_req  <= 1'b0;
         r_mem_addr <= 32'd0;
         r_cnt      <= '0;
         r_fill_idx <= '0;
         r_valid    <= '0;
      end else if (rdy_in) begin
         if (w_start) begin
            r_mem_req            <= 1'b1;
            r_mem_addr           <= w_miss_base;
            r_cnt                <= '0;
            r_fill_idx           <= w_miss_idx;
            r_valid[w_miss_idx]  <= 1'b0;
         end
         if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_valid[r_fill_idx] <= 1'b1;
               r_mem_req           <= 1'b0;
            end
         end
      end
   end

   // Tag is written when the refill starts so the line is ready at install
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && w_start) begin
         r_tag[w_miss_idx] <= w_miss_tag;
      end
   end

   // Beat data lands in ascending word order
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && w_beat) begin
         r_data[r_fill_idx][r_cnt] <= mem_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_cache
// Description : Scoreboard bench for instruction_cache: stimulus queues
//               expected fetch responses and refill addresses, a monitor
//               compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_cache;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        inst_ready;
   logic [31:0] inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;

   instruction_cache #(.INDEX_BIT(5), .LINE_WORDS(4)) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .fetch_req  (fetch_req),
      .fetch_pc   (fetch_pc),
      .inst_ready (inst_ready),
      .inst       (inst),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data)
   );

   typedef struct {
      logic [31:0] pc;
      logic        rdy;
      logic [31:0] inst;
   } fexp_t;

   fexp_t       fq[$];
   logic [31:0] aq[$];
   int          total = 0;
   int          bad   = 0;
   logic        prev_req = 1'b0;
   fexp_t       m_e;

   // Clock
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Run-away guard
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   // Monitor: fetch responses and refill request rises
   always @(negedge clk_in) begin
      if (fetch_req) begin
         if (fq.size() == 0) begin
            check("unexpected_fetch", 32'd1, 32'd0);
         end else begin
            m_e = fq.pop_front();
            check($sformatf("ready pc=%h", m_e.pc), {31'd0, inst_ready}, {31'd0, m_e.rdy});
            if (m_e.rdy && inst_ready)
               check($sformatf("inst pc=%h", m_e.pc), inst, m_e.inst);
         end
      end
      if (mem_req && !prev_req) begin
         if (aq.size() == 0) check("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
         else check("mem_addr", mem_addr, aq.pop_front());
      end
      prev_req = mem_req;
   end

   task automatic fetch(input logic [31:0] pc, input logic rdy, input logic [31:0] exp_inst);
      fexp_t e;
      e.pc = pc; e.rdy = rdy; e.inst = exp_inst;
      fq.push_back(e);
      fetch_req = 1'b1;
      fetch_pc  = pc;
      cyc();
      fetch_req = 1'b0;
   endtask

   task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] line_addr);
      aq.push_back(line_addr);
      fetch(pc, 1'b0, 32'd0);
   endtask

   // Serve one line {w3,w2,w1,w0} back to back, then expect mem_req low
   task automatic refill(input logic [127:0] line);
      int n = 0;
      while (!mem_req && n < 20) begin
         cyc();
         n++;
      end
      if (!mem_req) check("req_wait", 32'd0, 32'd1);
      for (int i = 0; i < 4; i++) begin
         mem_valid = 1'b1;
         mem_data  = line[i*32 +: 32];
         cyc();
      end
      mem_valid = 1'b0;
      check("req_drop", {31'd0, mem_req}, 32'd0);
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; fetch_req = 1'b0; fetch_pc = 32'd0;
      mem_valid = 1'b0; mem_data = 32'd0;
      repeat (3) cyc();
      rst_in = 1'b0;
      check("reset mem_req", {31'd0, mem_req}, 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);

      // Cold miss
      fetch_miss(32'h0000, 32'h0000);
      refill({32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013});
      fetch(32'h0000, 1'b1, 32'h00000013);
      fetch(32'h0008, 1'b1, 32'h00200113);
      fetch(32'h0004, 1'b1, 32'h00100093);
      fetch(32'h000C, 1'b1, 32'h00300193);

      // Compressed
      fetch_miss(32'h0100, 32'h0100);
      refill({32'h0, 32'h0, 32'h00014505, 32'h45814501});
      fetch(32'h0100, 1'b1, 32'h45814501);
      fetch(32'h0102, 1'b1, 32'h45054581);

      // Straddle across a line boundary (evicts line 0x0000)
      fetch_miss(32'h0200, 32'h0200);
      refill({32'h00930001, 32'h00000013, 32'h00000013, 32'h00000013});
      fetch(32'h020C, 1'b1, 32'h00930001);
      fetch_miss(32'h020E, 32'h0210);
      refill({32'h0, 32'h0, 32'h0, 32'h12345678});
      fetch(32'h020E, 1'b1, 32'h56780093);

      // Conflict on index 0
      fetch_miss(32'h0000, 32'h0000);
      refill({32'h11130013, 32'h11120013, 32'h11110013, 32'h11100013});
      fetch(32'h0000, 1'b1, 32'h11100013);
      fetch_miss(32'h0800, 32'h0800);
      refill({32'h22230013, 32'h22220013, 32'h22210013, 32'h22200013});
      fetch(32'h0800, 1'b1, 32'h22200013);
      fetch(32'h0210, 1'b1, 32'h12345678);
      fetch_miss(32'h0000, 32'h0000);
      refill({32'h11130013, 32'h11120013, 32'h11110013, 32'h11100013});
      fetch(32'h0004, 1'b1, 32'h11110013);

      // Gapped beats with a 3-cycle pause; junk beats during pause are ignored
      fetch_miss(32'h0300, 32'h0300);
      mem_valid = 1'b1; mem_data = 32'h33300013; cyc();
      mem_valid = 1'b1; mem_data = 32'h33310013; cyc();
      for (int i = 0; i < 3; i++) begin
         rdy_in = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEADBEEF; cyc();
         check("pause mem_req", {31'd0, mem_req}, 32'd1);
      end
      rdy_in = 1'b1; mem_valid = 1'b0; cyc();
      mem_valid = 1'b1; mem_data = 32'h33320013; cyc();
      mem_valid = 1'b1; mem_data = 32'h33330013; cyc();
      mem_valid = 1'b0;
      check("gap req_drop", {31'd0, mem_req}, 32'd0);
      fetch(32'h0300, 1'b1, 32'h33300013);
      fetch(32'h0304, 1'b1, 32'h33310013);
      fetch(32'h0308, 1'b1, 32'h33320013);
      fetch(32'h030C, 1'b1, 32'h33330013);

      // Index wrap: hi of the last line is line 0 with tag+1
      fetch_miss(32'h03FE, 32'h03F0);
      refill({32'h00B30001, 32'h0, 32'h0, 32'h0});
      fetch_miss(32'h03FE, 32'h0400);
      refill({32'h0, 32'h0, 32'h0, 32'hCAFE1234});
      fetch(32'h03FE, 1'b1, 32'h123400B3);

      // Reset during beat 2
      fetch_miss(32'h0500, 32'h0500);
      mem_valid = 1'b1; mem_data = 32'h55500013; cyc();
      mem_valid = 1'b1; mem_data = 32'h55510013; cyc();
      rst_in = 1'b1; mem_valid = 1'b1; mem_data = 32'h55520013; cyc();
      check("reset mid-fill mem_req", {31'd0, mem_req}, 32'd0);
      rst_in = 1'b0; mem_valid = 1'b0;
      cyc();
      fetch_miss(32'h0304, 32'h0300);
      refill({32'h33330013, 32'h33320013, 32'h33310013, 32'h33300013});
      fetch(32'h0304, 1'b1, 32'h33310013);

      repeat (3) cyc();
      check("fetch queue drained", fq.size(), 32'd0);
      check("addr queue drained", aq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
